// File: rtl/pa_dcache_dirty_ctrl.sv
// Dirty-bit SRAM access controller: arbitrates refill and store-hit writes with a
// clean-all walker that reads each index, hands dirty ways to writeback and clears them.
module pa_dcache_dirty_ctrl #(
  parameter int IDX_WIDTH = 10,
  parameter int INDEX_NUM = 256
) (
  input  logic                 forever_cpuclk,
  input  logic                 cpurst,
  input  logic                 rf_req,
  input  logic [IDX_WIDTH-1:0] rf_idx,
  input  logic [3:0]           rf_way,
  input  logic                 rf_dirty,
  input  logic                 st_req,
  input  logic [IDX_WIDTH-1:0] st_idx,
  input  logic [3:0]           st_way,
  output logic                 st_grant,
  input  logic                 flush_start,
  output logic                 flush_busy,
  output logic                 flush_done,
  output logic                 wb_req,
  output logic [IDX_WIDTH-1:0] wb_idx,
  output logic [3:0]           wb_way,
  input  logic                 wb_ack,
  output logic                 dirty_clk_en,
  output logic                 dirty_cen,
  output logic                 dirty_gwen,
  output logic [3:0]           dirty_wen,
  output logic [3:0]           dirty_din,
  output logic [IDX_WIDTH-1:0] dirty_idx,
  input  logic [3:0]           dirty_dout
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_CHK, S_WB, S_CLR, S_NEXT, S_DONE
  } state_t;

  state_t               state, state_nxt;
  logic [IDX_WIDTH-1:0] cnt, cnt_nxt;
  logic [IDX_WIDTH-1:0] wb_idx_nxt;
  logic [3:0]           wb_way_nxt;
  logic                 wb_req_nxt;
  logic                 busy_nxt;
  logic                 done_nxt;
  logic                 restart, restart_nxt;
  logic                 rd_capture;
  logic                 walker_slot;
  logic                 hazard;
  logic                 last_idx;

  assign walker_slot = ~rf_req & ~st_req;
  // Only the write that actually reaches the array can disturb the walker's snapshot.
  assign hazard      = rf_req ? (rf_idx == cnt) : (st_req & (st_idx == cnt));
  assign last_idx    = (cnt == IDX_WIDTH'(INDEX_NUM - 1));

  always_comb begin
    dirty_cen  = 1'b1;
    dirty_gwen = 1'b1;
    dirty_wen  = 4'hF;
    dirty_din  = 4'h0;
    dirty_idx  = '0;
    st_grant   = 1'b0;
    if (rf_req) begin
      dirty_cen  = 1'b0;
      dirty_gwen = 1'b0;
      dirty_wen  = ~rf_way;
      dirty_din  = {4{rf_dirty}};
      dirty_idx  = rf_idx;
    end else if (st_req) begin
      st_grant   = 1'b1;
      dirty_cen  = 1'b0;
      dirty_gwen = 1'b0;
      dirty_wen  = ~st_way;
      dirty_din  = 4'hF;
      dirty_idx  = st_idx;
    end else if (state == S_RD) begin
      dirty_cen  = 1'b0;
      dirty_idx  = cnt;
    end else if (state == S_CLR) begin
      dirty_cen  = 1'b0;
      dirty_gwen = 1'b0;
      dirty_wen  = ~wb_way;
      dirty_idx  = cnt;
    end
  end

  // The gated array clock must also tick in the cycle after a read so Q is captured.
  assign dirty_clk_en = ~dirty_cen | rd_capture;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    restart_nxt = restart;
    wb_req_nxt  = wb_req;
    wb_idx_nxt  = wb_idx;
    wb_way_nxt  = wb_way;
    busy_nxt    = flush_busy;
    done_nxt    = 1'b0;
    case (state)
      S_IDLE: begin
        if (flush_start) begin
          state_nxt   = S_RD;
          cnt_nxt     = '0;
          busy_nxt    = 1'b1;
          restart_nxt = 1'b0;
        end
      end
      S_RD: begin
        if (walker_slot) state_nxt = S_CHK;
      end
      S_CHK: begin
        if (hazard) begin
          state_nxt = S_RD;
        end else if (dirty_dout == 4'h0) begin
          state_nxt = S_NEXT;
        end else begin
          wb_req_nxt  = 1'b1;
          wb_idx_nxt  = cnt;
          wb_way_nxt  = dirty_dout;
          restart_nxt = 1'b0;
          state_nxt   = S_WB;
        end
      end
      S_WB: begin
        if (hazard) restart_nxt = 1'b1;
        if (wb_ack) begin
          wb_req_nxt = 1'b0;
          state_nxt  = S_CLR;
        end
      end
      S_CLR: begin
        // A preempting write to this index is re-examined after the clear lands.
        if (walker_slot) begin
          wb_idx_nxt  = '0;
          wb_way_nxt  = 4'h0;
          restart_nxt = 1'b0;
          state_nxt   = restart ? S_RD : S_NEXT;
        end else if (hazard) begin
          restart_nxt = 1'b1;
        end
      end
      S_NEXT: begin
        if (last_idx) begin
          state_nxt = S_DONE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt   = cnt + IDX_WIDTH'(1);
          state_nxt = S_RD;
        end
      end
      S_DONE: begin
        cnt_nxt   = '0;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      restart    <= 1'b0;
      rd_capture <= 1'b0;
      wb_req     <= 1'b0;
      wb_idx     <= '0;
      wb_way     <= 4'h0;
      flush_busy <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      restart    <= restart_nxt;
      rd_capture <= (state == S_RD) & walker_slot;
      wb_req     <= wb_req_nxt;
      wb_idx     <= wb_idx_nxt;
      wb_way     <= wb_way_nxt;
      flush_busy <= busy_nxt;
      flush_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_pa_dcache_dirty_ctrl.sv
// Self-checking bench for pa_dcache_dirty_ctrl: drives an array model from the DUT pins
// and compares its contents and the writeback stream against an intent-level reference.
module tb_pa_dcache_dirty_ctrl;
  localparam int IW = 10;
  localparam int NI = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rf_req = 0, rf_dirty = 0, st_req = 0, flush_start = 0, wb_ack = 0;
  logic [IW-1:0] rf_idx = '0, st_idx = '0;
  logic [3:0]    rf_way = '0, st_way = '0;
  logic          st_grant, flush_busy, flush_done, wb_req;
  logic [IW-1:0] wb_idx, dirty_idx;
  logic [3:0]    wb_way, dirty_wen, dirty_din;
  logic          dirty_clk_en, dirty_cen, dirty_gwen;
  logic [3:0]    dout_q = 4'h0;

  int tests_run = 0;
  int tests_failed = 0;
  logic [3:0] mem[1024];
  logic [3:0] ref_mem[1024];
  int done_cnt = 0;
  bit ack_enable = 1'b1;
  int ack_delay = 1;
  int wait_cnt = 0;
  logic [IW-1:0] hold_idx;
  logic [3:0]    hold_way;
  logic [IW-1:0] log_idx[$];
  logic [3:0]    log_way[$];

  pa_dcache_dirty_ctrl #(.IDX_WIDTH(IW), .INDEX_NUM(NI)) dut (
    .forever_cpuclk(clk), .cpurst(rst),
    .rf_req(rf_req), .rf_idx(rf_idx), .rf_way(rf_way), .rf_dirty(rf_dirty),
    .st_req(st_req), .st_idx(st_idx), .st_way(st_way), .st_grant(st_grant),
    .flush_start(flush_start), .flush_busy(flush_busy), .flush_done(flush_done),
    .wb_req(wb_req), .wb_idx(wb_idx), .wb_way(wb_way), .wb_ack(wb_ack),
    .dirty_clk_en(dirty_clk_en), .dirty_cen(dirty_cen), .dirty_gwen(dirty_gwen),
    .dirty_wen(dirty_wen), .dirty_din(dirty_din), .dirty_idx(dirty_idx),
    .dirty_dout(dout_q)
  );

  always #5 clk = ~clk;

  // Array model: only reacts when its gated clock is enabled.
  always @(posedge clk) begin
    if (dirty_clk_en && !dirty_cen) begin
      if (!dirty_gwen) mem[dirty_idx] = (mem[dirty_idx] & dirty_wen) | (dirty_din & ~dirty_wen);
      else dout_q <= mem[dirty_idx];
    end
  end

  // Writeback unit model: acks after ack_delay cycles, logs each accepted request.
  always @(negedge clk) begin
    if (rst) begin
      wb_ack = 1'b0;
      wait_cnt = 0;
    end else if (wb_ack) begin
      wb_ack = 1'b0;
      tests_run++;
      if (wb_req !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL wb_req_drop: wb_req=%b expected 0 after ack", wb_req);
      end
    end else if (wb_req && ack_enable) begin
      if (wait_cnt == 0) begin
        hold_idx = wb_idx;
        hold_way = wb_way;
      end else begin
        tests_run++;
        if ({wb_idx, wb_way} !== {hold_idx, hold_way}) begin
          tests_failed++;
          $display("[TB] FAIL wb_stable: idx=%0d way=%b expected idx=%0d way=%b",
                   wb_idx, wb_way, hold_idx, hold_way);
        end
      end
      if (wait_cnt >= ack_delay) begin
        wb_ack = 1'b1;
        log_idx.push_back(wb_idx);
        log_way.push_back(wb_way);
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end
  end

  always @(negedge clk) if (!rst && flush_done) done_cnt++;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic test_reset();
    logic [38:0] got;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 4'h0;
      ref_mem[i] = 4'h0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      got = {dirty_cen, dirty_gwen, dirty_wen, dirty_din, dirty_idx, dirty_clk_en,
             st_grant, wb_req, wb_way, wb_idx, flush_busy, flush_done};
      tests_run++;
      if (got !== {1'b1, 1'b1, 4'hF, 4'h0, 10'd0, 1'b0, 1'b0, 1'b0, 4'h0, 10'd0, 1'b0, 1'b0}) begin
        tests_failed++;
        $display("[TB] FAIL reset_values[%0d]: got %h", k, got);
      end
      rst = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_refill();
    logic [20:0] exp_pins;
    logic [3:0] w;
    int bad = 0;
    for (int n = 0; n < 8; n++) begin
      rf_req   = 1'b1;
      rf_idx   = (n == 0) ? IW'(5) : IW'($urandom_range(NI, 1023));
      w        = 4'b0001 << $urandom_range(0, 3);
      rf_way   = (n == 0) ? 4'b0010 : w;
      rf_dirty = (n == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      exp_pins = {1'b0, 1'b0, ~rf_way, {4{rf_dirty}}, rf_idx, 1'b1};
      ref_mem[rf_idx] = rf_dirty ? (ref_mem[rf_idx] | rf_way) : (ref_mem[rf_idx] & ~rf_way);
      #1;
      tests_run++;
      if ({dirty_cen, dirty_gwen, dirty_wen, dirty_din, dirty_idx, dirty_clk_en} !== exp_pins) begin
        tests_failed++;
        $display("[TB] FAIL refill_pins[%0d]: got cen=%b gwen=%b wen=%b din=%h idx=%0d clk_en=%b expected %h",
                 n, dirty_cen, dirty_gwen, dirty_wen, dirty_din, dirty_idx, dirty_clk_en, exp_pins);
      end
      @(negedge clk);
    end
    rf_req = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL refill_array: %0d entries differ, expected 0", bad);
    end
  endtask

  task automatic test_priority();
    int bad = 0;
    rf_req = 1'b1; rf_idx = 3; rf_way = 4'b0100; rf_dirty = 1'b1;
    st_req = 1'b1; st_idx = 7; st_way = 4'b0001;
    ref_mem[3] |= 4'b0100;
    #1;
    tests_run++;
    if ({st_grant, dirty_idx, dirty_wen} !== {1'b0, 10'd3, 4'b1011}) begin
      tests_failed++;
      $display("[TB] FAIL priority_rf: grant=%b idx=%0d wen=%b expected 0/3/1011", st_grant, dirty_idx, dirty_wen);
    end
    @(negedge clk);
    rf_req = 1'b0;
    ref_mem[7] |= 4'b0001;
    #1;
    tests_run++;
    if ({st_grant, dirty_cen, dirty_gwen, dirty_idx, dirty_wen, dirty_din} !== {1'b1, 1'b0, 1'b0, 10'd7, 4'b1110, 4'hF}) begin
      tests_failed++;
      $display("[TB] FAIL priority_st: grant=%b cen=%b idx=%0d wen=%b din=%h expected 1/0/7/1110/f",
               st_grant, dirty_cen, dirty_idx, dirty_wen, dirty_din);
    end
    @(negedge clk);
    st_req = 1'b0;
    #1;
    tests_run++;
    if ({st_grant, dirty_cen} !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL priority_idle: grant=%b cen=%b expected 0/1", st_grant, dirty_cen);
    end
    @(negedge clk);
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL priority_array: %0d entries differ, expected 0", bad);
    end
  endtask

  task automatic test_flush_basic();
    logic [3:0] pre[NI] = '{4'h0, 4'b1000, 4'h0, 4'b0011};
    int d0, bad;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) for (int i = 0; i < NI; i++) begin mem[i] = pre[i]; ref_mem[i] = pre[i]; end
      log_idx.delete(); log_way.delete();
      ack_delay = 1;
      d0 = done_cnt;
      flush_start = 1'b1;
      @(negedge clk);
      flush_start = 1'b0;
      tests_run++;
      if ({flush_busy, dirty_cen, dirty_gwen, dirty_idx} !== {1'b1, 1'b0, 1'b1, 10'd0}) begin
        tests_failed++;
        $display("[TB] FAIL flush_first_read: busy=%b cen=%b gwen=%b idx=%0d expected 1/0/1/0",
                 flush_busy, dirty_cen, dirty_gwen, dirty_idx);
      end
      @(negedge clk);
      tests_run++;
      if ({dirty_clk_en, dirty_cen} !== 2'b11) begin
        tests_failed++;
        $display("[TB] FAIL capture_clk_en: clk_en=%b cen=%b expected 1/1", dirty_clk_en, dirty_cen);
      end
      flush_start = 1'b1;
      @(negedge clk);
      flush_start = 1'b0;
      for (int c = 0; c < 200 && done_cnt == d0; c++) @(negedge clk);
      repeat (10) @(negedge clk);
      tests_run++;
      if (done_cnt != d0 + 1 || flush_busy !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL flush_done_count: done pulses=%0d busy=%b expected 1/0", done_cnt - d0, flush_busy);
      end
      for (int i = 0; i < NI; i++) ref_mem[i] = 4'h0;
      tests_run++;
      if (pass == 0 ? (log_idx.size() != 2 || log_idx[0] !== 10'd1 || log_way[0] !== 4'b1000 ||
                       log_idx[1] !== 10'd3 || log_way[1] !== 4'b0011)
                    : (log_idx.size() != 0)) begin
        tests_failed++;
        $display("[TB] FAIL flush_wb_list[%0d]: %0d requests, first idx=%0d way=%b; expected %0d",
                 pass, log_idx.size(), log_idx.size() > 0 ? log_idx[0] : 0,
                 log_way.size() > 0 ? log_way[0] : 4'h0, pass == 0 ? 2 : 0);
      end
      bad = 0;
      for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
      tests_run++;
      if (bad != 0) begin
        tests_failed++;
        $display("[TB] FAIL flush_array[%0d]: %0d entries differ, expected 0", pass, bad);
      end
    end
  endtask

  task automatic test_hazard();
    int d0, bad = 0;
    bit found = 0;
    for (int i = 0; i < NI; i++) begin mem[i] = (i == 1) ? 4'b1000 : 4'h0; ref_mem[i] = mem[i]; end
    log_idx.delete(); log_way.delete();
    ack_delay = 3;
    d0 = done_cnt;
    flush_start = 1'b1;
    @(negedge clk);
    flush_start = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (wb_req) begin found = 1; break; end
      @(negedge clk);
    end
    tests_run++;
    if (!found || wb_idx !== 10'd1 || wb_way !== 4'b1000) begin
      tests_failed++;
      $display("[TB] FAIL hazard_first_wb: seen=%b idx=%0d way=%b expected 1/1/1000", found, wb_idx, wb_way);
    end
    st_req = 1'b1; st_idx = 1; st_way = 4'b0001;
    ref_mem[1] |= 4'b0001;
    #1;
    tests_run++;
    if (st_grant !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL hazard_store_grant: grant=%b expected 1", st_grant);
    end
    @(negedge clk);
    st_req = 1'b0;
    found = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!dirty_cen && !dirty_gwen && dirty_idx == 10'd1) begin found = 1; break; end
    end
    tests_run++;
    if (!found || dirty_wen !== 4'b0111 || dirty_din !== 4'h0) begin
      tests_failed++;
      $display("[TB] FAIL hazard_clear_pins: seen=%b wen=%b din=%h expected 1/0111/0", found, dirty_wen, dirty_din);
    end
    for (int c = 0; c < 200 && done_cnt == d0; c++) @(negedge clk);
    @(negedge clk);
    ref_mem[1] = 4'h0;
    tests_run++;
    if (done_cnt != d0 + 1 || log_idx.size() != 2 || log_idx[0] !== 10'd1 || log_way[0] !== 4'b1000 ||
        log_idx[1] !== 10'd1 || log_way[1] !== 4'b0001) begin
      tests_failed++;
      $display("[TB] FAIL hazard_wb_list: done=%0d requests=%0d expected 1 done, (1,1000),(1,0001)",
               done_cnt - d0, log_idx.size());
    end
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL hazard_array: %0d entries differ, expected 0", bad);
    end
  endtask

  task automatic test_async_reset();
    int d0;
    bit found = 0;
    for (int i = 0; i < NI; i++) begin mem[i] = (i == 0) ? 4'b0100 : 4'h0; ref_mem[i] = mem[i]; end
    ack_enable = 1'b0;
    flush_start = 1'b1;
    @(negedge clk);
    flush_start = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (wb_req) begin found = 1; break; end
      @(negedge clk);
    end
    d0 = done_cnt;
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (!found || {wb_req, flush_busy, dirty_cen, dirty_clk_en} !== 4'b0010) begin
      tests_failed++;
      $display("[TB] FAIL async_reset: seen=%b wb_req=%b busy=%b cen=%b clk_en=%b expected 0/0/1/0",
               found, wb_req, flush_busy, dirty_cen, dirty_clk_en);
    end
    @(negedge clk);
    rst = 1'b0;
    ack_enable = 1'b1;
    repeat (10) @(negedge clk);
    tests_run++;
    if (done_cnt != d0 || wb_req !== 1'b0 || flush_busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset_after: done pulses=%0d wb_req=%b busy=%b expected 0/0/0",
               done_cnt - d0, wb_req, flush_busy);
    end
  endtask

  task automatic test_random_flush();
    logic [IW-1:0] exp_idx[$];
    logic [3:0]    exp_way[$];
    int d0, bad;
    for (int it = 0; it < 3; it++) begin
      exp_idx.delete(); exp_way.delete();
      for (int i = 0; i < NI; i++) begin
        mem[i] = 4'($urandom_range(0, 15));
        ref_mem[i] = mem[i];
        if (mem[i] != 4'h0) begin exp_idx.push_back(IW'(i)); exp_way.push_back(mem[i]); end
      end
      log_idx.delete(); log_way.delete();
      ack_delay = $urandom_range(0, 3);
      d0 = done_cnt;
      flush_start = 1'b1;
      for (int c = 0; c < 3000; c++) begin
        @(negedge clk);
        flush_start = 1'b0;
        if (done_cnt != d0) break;
        if (c == 30) begin
          tests_run++;
          if (log_idx.size() != 0 || flush_busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL random_stall[%0d]: requests=%0d busy=%b expected 0/1", it, log_idx.size(), flush_busy);
          end
        end
        rf_req = 1'b0;
        st_req = 1'b0;
        if (c < 30 || $urandom_range(0, 1) == 1) begin
          st_req = 1'b1;
          st_idx = IW'($urandom_range(NI, 31));
          st_way = 4'b0001 << $urandom_range(0, 3);
        end
        if (c >= 30 && $urandom_range(0, 3) == 0) begin
          rf_req   = 1'b1;
          rf_idx   = IW'($urandom_range(NI, 31));
          rf_way   = 4'b0001 << $urandom_range(0, 3);
          rf_dirty = 1'($urandom_range(0, 1));
        end
        if (rf_req) ref_mem[rf_idx] = rf_dirty ? (ref_mem[rf_idx] | rf_way) : (ref_mem[rf_idx] & ~rf_way);
        else if (st_req) ref_mem[st_idx] |= st_way;
      end
      rf_req = 1'b0;
      st_req = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < NI; i++) ref_mem[i] = 4'h0;
      tests_run++;
      if (done_cnt != d0 + 1 || flush_busy !== 1'b0 || log_idx != exp_idx || log_way != exp_way) begin
        tests_failed++;
        $display("[TB] FAIL random_flush[%0d]: done=%0d busy=%b requests=%0d expected 1/0/%0d",
                 it, done_cnt - d0, flush_busy, log_idx.size(), exp_idx.size());
      end
      bad = 0;
      for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
      tests_run++;
      if (bad != 0) begin
        tests_failed++;
        $display("[TB] FAIL random_array[%0d]: %0d entries differ, expected 0", it, bad);
      end
    end
  endtask

  initial begin
    test_reset();
    test_refill();
    test_priority();
    test_flush_basic();
    test_hazard();
    test_async_reset();
    test_random_flush();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pa_dcache_dirty_ctrl.md
Name: pa_dcache_dirty_ctrl

Overview:
Access controller for the 4-way dcache dirty-bit SRAM (one 4-bit word per index, one bit per way). Arbitrates single-cycle writes from refill and store-hit with a multi-cycle clean-all walker. The walker reads each index, hands dirty ways to the writeback unit and clears the bits once writeback is accepted. Drives the dirty array's clock-enable, CEN, GWEN, WEN, D and index pins; consumes its Q output.

Parameters:
IDX_WIDTH, 10, width of dirty_idx bus; must match the array port.
INDEX_NUM, 256, number of valid indices walked by a flush (16K dcache config); last index = INDEX_NUM-1.

Ports:
forever_cpuclk  input  1  ungated core clock.
cpurst  input  1  asynchronous reset, active-high.
rf_req  input  1  refill dirty write request (highest priority).
rf_idx  input  IDX_WIDTH  refill index.
rf_way  input  4  one-hot way being written by refill.
rf_dirty  input  1  value written to the refill way's bit.
st_req  input  1  store-hit request to set a dirty bit.
st_idx  input  IDX_WIDTH  store index.
st_way  input  4  one-hot store way.
st_grant  output  1  store request accepted this cycle.
flush_start  input  1  one-cycle pulse; starts clean-all walk; ignored unless idle.
flush_busy  output  1  walker active.
flush_done  output  1  one-cycle pulse after the last index is cleared.
wb_req  output  1  writeback request for dirty ways at wb_idx.
wb_idx  output  IDX_WIDTH  index under writeback.
wb_way  output  4  dirty-way mask under writeback.
wb_ack  input  1  writeback unit accepted wb_req.
dirty_clk_en  output  1  local clock enable for the array's gated clock.
dirty_cen  output  1  array chip enable, active-low.
dirty_gwen  output  1  global write enable, active-low (1 = read).
dirty_wen  output  4  per-bit write enable, active-low.
dirty_din  output  4  write data.
dirty_idx  output  IDX_WIDTH  array index.
dirty_dout  input  4  array read data; valid the cycle after a read.

Behaviour:
- All array-pin outputs combinational from the arbiter; everything else registered. Reset/idle values: dirty_cen=1, dirty_gwen=1, dirty_wen=4'hF, dirty_din=0, dirty_idx=0, dirty_clk_en=0, st_grant=0, wb_req=0, wb_way=0, wb_idx=0, flush_busy=0, flush_done=0, FSM=IDLE, walk counter=0.
- Fixed priority per cycle: rf_req > st_req > walker access. rf_req: cen=0, gwen=0, wen=~rf_way, din={4{rf_dirty}}. Store grant: cen=0, gwen=0, wen=~st_way, din=4'hF; st_grant=st_req & ~rf_req (combinational).
- dirty_clk_en = 1 in any cycle with cen=0, and the cycle after a walker read (capture window).
- Walker FSM:
  - IDLE: flush_start -> RD, counter=0, flush_busy=1.
  - RD: issue read (cen=0, gwen=1, idx=counter) if not preempted; a preempted RD holds. Issued -> CHK.
  - CHK: sample dirty_dout & {4{1}}. Mask 0 -> NEXT. Otherwise wb_req=1, wb_idx=counter, wb_way=mask -> WB.
  - WB: hold wb_req/wb_idx/wb_way stable until wb_ack. On wb_ack: wb_req=0 -> CLR.
  - CLR: write cen=0, gwen=0, wen=~wb_way, din=0 when not preempted; a preempted CLR holds. Done -> NEXT.
  - NEXT: if counter==INDEX_NUM-1 -> DONE; else counter+1 -> RD.
  - DONE: flush_done=1 for one cycle, flush_busy=0 -> IDLE.
- Hazard: a refill or store write to idx==counter while FSM in CHK or WB, before wb_ack, sets a restart flag. At CHK the walker returns to RD without raising wb_req. In WB, wb_req is held until ack, CLR is still performed, and then the walker re-enters RD for the same index (bit set after snapshot is re-examined, not lost).
- A write to the walker index on the same cycle as the CLR write is impossible: the preempting write wins, CLR holds one cycle and then executes. A store setting a bit in a way not in wb_way is preserved, since wen masks only wb_way.
- flush_start while busy is ignored. Counter width IDX_WIDTH, no wrap beyond INDEX_NUM-1.
- Reset asserted mid-walk: all state returns to reset values immediately. wb_req drops without waiting for wb_ack; no flush_done.

Test Plan:
- Reset, then rf_req idx=5 way=4'b0010 dirty=1 -> same cycle cen=0, gwen=0, wen=4'b1101, din=4'hF, idx=5, dirty_clk_en=1.
- Simultaneous rf_req idx=3 and st_req idx=7 -> refill drives pins, st_grant=0; next cycle with st_req held -> st_grant=1, idx=7.
- INDEX_NUM=4, array preloaded {0,4'b1000,0,4'b0011}, flush_start, wb_ack one cycle after each wb_req -> exactly wb_req at idx1 way 1000 and idx3 way 0011, clears issued, flush_done once, afterwards all reads return 0.
- During WB at idx=1 (wb_way=4'b1000), store sets way 4'b0001 at idx 1 -> CLR wen=4'b0111, walker re-reads idx1, issues wb_req way=4'b0001.
- Continuous st_req to other indices throughout flush -> walker stalls in RD/CLR, never corrupts, completes after stores stop.
- cpurst pulse while wb_req=1 -> wb_req=0, flush_busy=0, cen=1 asynchronously; no flush_done.
